// File: rtl/pipo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipo_ctrl_pkg
// Shared definitions for the PIPO load arbiter:
//   - pipo_state_e : controller states (IDLE, LOAD, HOLD)
//   - DEF_*        : default parameter values used by the arbiter top
//   - rr_index     : modular index helper for round-robin scanning
// ---------------------------------------------------------------------------
package pipo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } pipo_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_HOLD_CYCLES = 2;

    // (base + offset) mod n; n need not be a power of two.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Scans the request vector
// starting at the pointer and wrapping past NUM_REQ-1 to 0; the first set
// request wins.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : index where the scan starts (highest priority this round)
//   grant : one-hot grant (all zero when no request)
//   idx   : binary index of the granted requester (0 when no request)
//   any   : at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter
    import pipo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = rr_index(int'(ptr), i, NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// ---------------------------------------------------------------------------
// pipo_load_arbiter
// Arbitrates several requesters onto one shared PIPO register. A winner is
// accepted in IDLE, its data is driven into the PIPO for one LOAD cycle, and
// the value is then held for HOLD_CYCLES before the next accept.
// Ports:
//   Clk_In          : clock, rising edge
//   Reset_N_In      : asynchronous active-low reset
//   Req_Valid_In    : per-requester load request
//   Req_Data_In     : flattened request data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Req_Ready_Out   : one-hot accept (IDLE only)
//   Grant_Id_Out    : index of the requester whose data the PIPO holds
//   Busy_Out        : high in LOAD and HOLD
//   PIPO_Enable_Out : PIPO enable, set at the first accept and kept high
//   PIPO_Load_Out   : PIPO load strobe, high during LOAD
//   PIPO_Data_Out   : PIPO parallel data (last captured value)
//   Load_Done_Out   : one-cycle pulse once the PIPO output shows the data
// ---------------------------------------------------------------------------
module pipo_load_arbiter
    import pipo_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                          Clk_In,
    input  logic                          Reset_N_In,
    input  logic [NUM_REQ-1:0]            Req_Valid_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
    output logic [NUM_REQ-1:0]            Req_Ready_Out,
    output logic [$clog2(NUM_REQ)-1:0]    Grant_Id_Out,
    output logic                          Busy_Out,
    output logic                          PIPO_Enable_Out,
    output logic                          PIPO_Load_Out,
    output logic [DATA_WIDTH-1:0]         PIPO_Data_Out,
    output logic                          Load_Done_Out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    pipo_state_e          state_q;
    pipo_state_e          state_d;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 accept;

    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      gid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  en_q;
    logic                  done_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (Req_Valid_In),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        Req_Ready_Out = '0;
        PIPO_Load_Out = 1'b0;
        Busy_Out      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Ready is gated by reset so every output reads zero while
                // reset is held, even with requests pending.
                if (arb_any && Reset_N_In) begin
                    Req_Ready_Out = arb_grant;
                    accept        = 1'b1;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                PIPO_Load_Out = 1'b1;
                Busy_Out      = 1'b1;
                state_d       = ST_HOLD;
            end
            ST_HOLD: begin
                Busy_Out = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            ptr_q  <= '0;
            gid_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // The PIPO samples during LOAD, so its output is valid in the
            // first HOLD cycle; that is where the done pulse lands.
            done_q <= (state_q == ST_LOAD);
            if (accept) begin
                data_q <= Req_Data_In[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                gid_q  <= arb_idx;
                ptr_q  <= IDX_W'(rr_index(int'(arb_idx), 1, NUM_REQ));
                en_q   <= 1'b1;
            end
            // Counter holds remaining HOLD cycles after the current one.
            if (state_q == ST_LOAD) begin
                cnt_q <= CNT_W'(HOLD_CYCLES - 1);
            end else if (state_q == ST_HOLD && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign Grant_Id_Out    = gid_q;
    assign PIPO_Data_Out   = data_q;
    assign PIPO_Enable_Out = en_q;
    assign Load_Done_Out   = done_q;

endmodule

// File: doc/pipo_load_arbiter.md
PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one 32-bit PIPO register (legal 2..8).
REQ-002 Parameter DATA_WIDTH, default 32, width of PIPO data.
REQ-003 Parameter HOLD_CYCLES, default 2, minimum cycles the loaded value is held before the next load (legal >=1).
REQ-004 Clk_In  input  1  single clock; all logic on rising edge.
REQ-005 Reset_N_In  input  1  reset, asynchronous and active-low.
REQ-006 Req_Valid_In  input  NUM_REQ  per-requester load request.
REQ-007 Req_Data_In  input  NUM_REQ*DATA_WIDTH  flattened request data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Req_Ready_Out  output  NUM_REQ  one-hot accept; transfer occurs when Req_Valid_In[i] and Req_Ready_Out[i] are both high.
REQ-009 Grant_Id_Out  output  clog2(NUM_REQ)  index of the requester whose data the PIPO currently holds.
REQ-010 Busy_Out  output  1  high in the LOAD and HOLD states.
REQ-011 PIPO_Enable_Out  output  1  drives PIPO Enable_In.
REQ-012 PIPO_Load_Out  output  1  drives PIPO Load_Data_Signal_In.
REQ-013 PIPO_Data_Out  output  DATA_WIDTH  drives PIPO Parallel_Data_In.
REQ-014 Load_Done_Out  output  1  one-cycle pulse when PIPO output reflects the granted data.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and HOLD.
REQ-016 In IDLE with any valid request, Req_Ready_Out SHALL combinationally assert one-hot for the first valid index at or after the round-robin pointer, wrapping past NUM_REQ-1 to 0.
REQ-017 In IDLE with no valid request, Req_Ready_Out SHALL be all zero and the FSM SHALL stay in IDLE.
REQ-018 On accept: capture data into an internal register; set Grant_Id_Out to the index; set pointer to (index+1) mod NUM_REQ; next state LOAD.
REQ-019 LOAD lasts exactly one cycle: PIPO_Load_Out=1, PIPO_Enable_Out=1, PIPO_Data_Out=captured data; next state HOLD.
REQ-020 HOLD lasts exactly HOLD_CYCLES cycles (down-counter): PIPO_Load_Out=0; Load_Done_Out=1 in the first HOLD cycle only; then IDLE.
REQ-021 Latency: accept in cycle N, load in N+1, Load_Done_Out in N+2; earliest next accept in N+2+HOLD_CYCLES.
REQ-022 PIPO_Enable_Out SHALL be 0 from reset until the first LOAD, then 1 permanently until reset.
REQ-023 Req_Ready_Out SHALL be all zero in LOAD and HOLD; requests arriving then SHALL wait with no loss.
REQ-024 Requesters SHALL hold valid and data stable until accepted; a valid deasserted before accept SHALL NOT be granted.
REQ-025 PIPO_Data_Out SHALL hold the last captured value outside LOAD.

Reset
REQ-026 Asserting Reset_N_In low SHALL immediately force: state IDLE, pointer 0, Grant_Id_Out 0, captured data 0, HOLD counter 0, and all outputs 0.
REQ-027 Reset mid-LOAD or mid-HOLD SHALL abandon the transfer without a Load_Done_Out pulse; the first grant after release starts at index 0.

Structure
REQ-028 State enum (IDLE/LOAD/HOLD) and default parameter constants SHALL live in a shared package pipo_ctrl_pkg.
REQ-029 Round-robin selection SHALL be one sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant and index), with all other logic in the top module.

Verification
REQ-030 Reset release, all valids low for 5 cycles -> PIPO_Enable_Out=0, Busy_Out=0, all outputs 0.
REQ-031 Single request: req 2 valid with 0xDEADBEEF in cycle N -> Req_Ready_Out=4'b0100 in N, PIPO_Load_Out=1 with 0xDEADBEEF in N+1, Load_Done_Out and Grant_Id_Out=2 in N+2, with the PIPO output reading 0xDEADBEEF.
REQ-032 All four valids held high continuously -> grant order 0,1,2,3,0; successive accepts spaced 2+HOLD_CYCLES cycles (4 at default).
REQ-033 Wrap-around: after req 3 is granted, reqs 0 and 3 both valid -> req 0 granted first.
REQ-034 Reset_N_In pulsed low during HOLD -> outputs 0 asynchronously, no Load_Done_Out; next grant with reqs 1 and 2 both valid goes to req 1.
REQ-035 Valid on req 1 raised during HOLD -> ready first asserts in the IDLE cycle after HOLD ends, and data is loaded unchanged.
